// File: rtl/acc_drain_pkg.sv
// ============================================================================
// Module   : acc_drain_pkg
// Brief    : Shared FP16 constants and drain FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_drain_pkg;

    localparam int          FP16_BIAS   = 15;
    localparam logic [15:0] FP16_INF    = 16'h7C00;
    localparam int          FP16_MANT_W = 10;
    localparam int          FP16_EXP_W  = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/acc_drain_fp16_fx_to_fp16.sv
// ============================================================================
// Module   : fx_to_fp16
// Brief    : Combinational signed fixed-point (with 5-bit exponent) to FP16.
//            ACC_DRAIN_RNE_EN selects round-to-nearest-even, else truncation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fx_to_fp16
    import acc_drain_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [4:0]           exp,
    output logic [15:0]          fp16
);

    localparam int c_pw = $clog2(ACC_WIDTH);

    logic                   w_sign;
    logic [ACC_WIDTH-1:0]   w_mag;
    logic [ACC_WIDTH-1:0]   w_norm;
    logic [c_pw-1:0]        w_p;
    logic [c_pw-1:0]        w_sh;
    logic [FP16_MANT_W-1:0] w_mant_raw;
    logic [FP16_MANT_W-1:0] w_mant;
    logic                   w_carry;
    logic [11:0]            w_e;
    logic [11:0]            w_e_fin;

    assign w_sign = acc[ACC_WIDTH-1];
    // Unsigned magnitude keeps the most negative value representable.
    assign w_mag  = w_sign ? (-acc) : acc;

    always_comb begin
        w_p = '0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (w_mag[i]) w_p = c_pw'(i);
        end
    end

    // Leading one moved to the MSB; mantissa, guard and sticky follow it.
    assign w_sh       = c_pw'(ACC_WIDTH - 1) - w_p;
    assign w_norm     = w_mag << w_sh;
    assign w_mant_raw = w_norm[ACC_WIDTH-2 -: FP16_MANT_W];
    assign w_e        = 12'(exp) + 12'(w_p) - 12'(FRAC_BITS);

`ifdef ACC_DRAIN_RNE_EN
    logic w_guard;
    logic w_sticky;
    logic w_round_up;
    logic w_unused;

    assign w_guard    = w_norm[ACC_WIDTH-2-FP16_MANT_W];
    assign w_sticky   = |w_norm[ACC_WIDTH-3-FP16_MANT_W:0];
    assign w_round_up = w_guard & (w_sticky | w_mant_raw[0]);
    assign {w_carry, w_mant} = {1'b0, w_mant_raw} + (FP16_MANT_W+1)'(w_round_up);
    assign w_unused   = w_norm[ACC_WIDTH-1];
`else
    logic w_unused;

    assign w_carry  = 1'b0;
    assign w_mant   = w_mant_raw;
    assign w_unused = ^{w_norm[ACC_WIDTH-1], w_norm[ACC_WIDTH-2-FP16_MANT_W:0]};
`endif

    assign w_e_fin = w_e + 12'(w_carry);

    always_comb begin
        fp16 = '0;
        if (w_mag == '0) begin
            fp16 = '0;
        end else if ($signed(w_e_fin) >= 12'sd31) begin
            fp16 = {w_sign, FP16_INF[14:0]};
        end else if ($signed(w_e_fin) <= 12'sd0) begin
            fp16 = '0;
        end else begin
            fp16 = {w_sign, w_e_fin[FP16_EXP_W-1:0], w_mant};
        end
    end

endmodule

`default_nettype wire

// File: rtl/acc_drain_fp16.sv
// ============================================================================
// Module   : acc_drain_fp16
// Brief    : Snapshots the MAC array accumulators on done_in and streams them
//            out as FP16 in row-major order. Option: ACC_DRAIN_RNE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_drain_fp16
    import acc_drain_pkg::*;
#(
    parameter int N         = 2,
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10,
    parameter int IDX_W     = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       done_in,
    input  logic [N*N*ACC_WIDTH-1:0]   acc_in,
    input  logic [N*N*5-1:0]           exp_in,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [15:0]                out_data,
    output logic [IDX_W-1:0]           out_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic                       drop
);

    logic [ACC_WIDTH-1:0] r_acc_snap [N*N];
    logic [4:0]           r_exp_snap [N*N];
    drain_state_t         r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [15:0]          w_fp16;
    logic                 w_take;
    logic                 w_last_accept;
    logic                 w_snap_en;

    fx_to_fp16 #(
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_fx_to_fp16 (
        .acc  (r_acc_snap[r_idx]),
        .exp  (r_exp_snap[r_idx]),
        .fp16 (w_fp16)
    );

    assign w_take        = !out_valid || out_ready;
    assign w_last_accept = (r_state == DRAIN) && out_valid && out_last && out_ready;
    // A new tile may be captured in IDLE or on the very cycle the last entry leaves.
    assign w_snap_en     = done_in && ((r_state == IDLE) || w_last_accept);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N * N; k++) begin
                r_acc_snap[k] <= '0;
                r_exp_snap[k] <= '0;
            end
        end else if (w_snap_en) begin
            for (int k = 0; k < N * N; k++) begin
                r_acc_snap[k] <= acc_in[k*ACC_WIDTH +: ACC_WIDTH];
                r_exp_snap[k] <= exp_in[k*5 +: 5];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (done_in) begin
                        r_idx   <= '0;
                        r_state <= DRAIN;
                        busy    <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (done_in && !w_last_accept) drop <= 1'b1;
                    if (w_take) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (done_in) begin
                                r_idx <= '0;
                            end else begin
                                r_state <= IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            out_data  <= w_fp16;
                            out_idx   <= r_idx;
                            out_last  <= (r_idx == IDX_W'(N * N - 1));
                            out_valid <= 1'b1;
                            r_idx     <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
